dither_arbiter: RTL and testbench
=================================

# dither_arbiter

Shares the single free-running 20-bit signed LFSR dither source among several delta-sigma modulator channels. Each cycle it grants the current LFSR sample to at most one requesting channel using round-robin order, so no two channels ever receive the same sample. It also holds a start-up state machine that discards the first LFSR samples after enable. It sits between `lfsr` and the per-channel modulator dither inputs.

## Interface
- NUM_REQ, 4, number of requesting channels (2..8)
- WIDTH, 20, dither sample width; matches LFSR output
- WARMUP, 16, LFSR samples discarded after enable rises (1..255)
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous active-low reset
- enable_i  input  1  run request; level-sensitive
- lfsr_i  input  WIDTH  signed LFSR sample; changes every cycle
- req_i  input  NUM_REQ  per-channel dither request; held until granted
- scale_i  input  2  arithmetic right-shift amount (macro-dependent)
- gnt_o  output  NUM_REQ  one-hot grant, registered
- dither_o  output  WIDTH  signed granted sample, registered
- dither_valid_o  output  1  dither_o/gnt_o valid this cycle
- running_o  output  1  high in RUN state
- gnt_count_o  output  16  total grants since enable, saturating

## Operation
- States: IDLE, WARMUP, RUN.
- IDLE: enable_i=1 -> WARMUP. Warm-up counter loads 0.
- WARMUP: counter increments every cycle. At counter==WARMUP-1 -> RUN. No grants are issued.
- RUN: this state arbitrates. enable_i=0 in any state -> IDLE on the next edge.
- Arbitration in RUN: the grant goes to the first set req_i bit at or after the round-robin pointer, searching upward with wrap from NUM_REQ-1 to 0.
- After a grant to channel k, the pointer becomes (k+1) mod NUM_REQ. With no requests, the pointer is unchanged.
- On a grant, dither_o = lfsr_i >>> scale_i, sampled in the grant cycle. dither_valid_o=1, gnt_o=one-hot(k), gnt_count_o increments, saturating at 16'hFFFF.
- With no grant, dither_valid_o=0 and gnt_o=0. dither_o holds its last value.
- Requester handshake: req_i[k] stays high until the cycle in which gnt_o[k]=1 is observed. The requester may drop req_i[k] in that cycle or keep it high for another sample.
- On entry to IDLE: gnt_count_o clears to 0 and the pointer resets to 0.

## Timing
- Reset values: state IDLE, gnt_o=0, dither_o=0, dither_valid_o=0, running_o=0, gnt_count_o=0, pointer=0, warm-up counter=0.
- Latency: req_i and lfsr_i sampled at edge N appear on gnt_o/dither_o after edge N. This is 1 cycle.
- running_o rises on the edge that enters RUN. The first possible grant is sampled on that same edge's following cycle, i.e. WARMUP+1 edges after enable_i is first sampled high.
- Only one grant per cycle. Each LFSR sample is used at most once.
- enable_i dropping in RUN: outputs are zeroed on the next edge (gnt_o=0, dither_valid_o=0, running_o=0). A request pending in that cycle is not granted.
- enable_i toggling 1->0->1 restarts a full WARMUP.
- Asynchronous reset mid-operation: all outputs go to reset values immediately, with no wait for a clock edge.
- Shift by scale_i is arithmetic: the sign bit is replicated and the width is unchanged.

## Configuration
- DITHER_ARB_SCALE_EN defined: the scale_i port exists. dither_o = lfsr_i >>> scale_i (shift 0..3).
- DITHER_ARB_SCALE_EN undefined: the scale_i port is absent and dither_o = lfsr_i unmodified.
- All other behaviour is identical in both builds.

## Test plan
- Reset/warm-up: reset low then high, enable_i=1, req_i=4'b1111 -> dither_valid_o=0 for 17 edges. Then gnt_o=0001, 0010, 0100, 1000, 0001 on consecutive cycles, and dither_o equals the lfsr_i of the previous cycle each time.
- Sparse requests: in RUN with pointer=0, req_i=4'b1010 held -> grants 0010, 1000, 0010. With req_i=0, dither_valid_o=0 and the pointer is unchanged.
- Scale (macro on): lfsr_i=20'h80000, scale_i=2 -> dither_o=20'hE0000. With lfsr_i=20'h7FFFF, scale_i=3 -> 20'h0FFFF.
- Enable drop: enable_i->0 in RUN with req_i=4'b0001 -> next cycle gnt_o=0, running_o=0, gnt_count_o=0. Re-enable -> 16 cycles of no grants again.
- Async reset mid-RUN: assert reset between edges -> gnt_o, dither_valid_o and gnt_count_o are 0 at once. After release, the first grant goes to channel 0.
- Saturation: force 65535 grants, keep requesting -> gnt_count_o stays 16'hFFFF and grants continue.

Source files
------------

// File: rtl/dither_arbiter_if.sv
// Bundles the dither arbiter's request, LFSR and grant signals.
// scale_i exists only when DITHER_ARB_SCALE_EN is defined.
interface dither_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 20
);
  logic                    enable_i;
  logic signed [WIDTH-1:0] lfsr_i;
  logic [NUM_REQ-1:0]      req_i;
`ifdef DITHER_ARB_SCALE_EN
  logic [1:0]              scale_i;
`endif
  logic [NUM_REQ-1:0]      gnt_o;
  logic signed [WIDTH-1:0] dither_o;
  logic                    dither_valid_o;
  logic                    running_o;
  logic [15:0]             gnt_count_o;

  modport master (
    output enable_i, lfsr_i, req_i,
`ifdef DITHER_ARB_SCALE_EN
    output scale_i,
`endif
    input  gnt_o, dither_o, dither_valid_o, running_o, gnt_count_o
  );

  modport slave (
    input  enable_i, lfsr_i, req_i,
`ifdef DITHER_ARB_SCALE_EN
    input  scale_i,
`endif
    output gnt_o, dither_o, dither_valid_o, running_o, gnt_count_o
  );
endinterface

// File: rtl/dither_arbiter.sv
// Round-robin distribution of one LFSR dither sample per cycle to requesting channels,
// gated by an IDLE/WARMUP/RUN start-up FSM. Define DITHER_ARB_SCALE_EN to enable scale_i.
module dither_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 20,
  parameter int WARMUP  = 16
) (
  input  logic            clock,
  input  logic            reset,
  dither_arbiter_if.slave bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_RUN} state_t;

  state_t                  state, state_nxt;
  logic [7:0]              wcnt, wcnt_nxt;
  logic                    grant_en, hit, grant;
  logic [PW-1:0]           ptr, idx, probe, ptr_nxt;
  logic signed [WIDTH-1:0] dither_p0;
  logic [NUM_REQ-1:0]      gnt_p1;
  logic signed [WIDTH-1:0] dither_p1;
  logic                    vld_p1;
  logic [15:0]             cnt_p1;

`ifdef DITHER_ARB_SCALE_EN
  function automatic logic signed [WIDTH-1:0] scale_sample(
    input logic signed [WIDTH-1:0] s, input logic [1:0] sh);
    return s >>> sh;
  endfunction
  assign dither_p0 = scale_sample(bus.lfsr_i, bus.scale_i);
`else
  function automatic logic signed [WIDTH-1:0] scale_sample(
    input logic signed [WIDTH-1:0] s);
    return s;
  endfunction
  assign dither_p0 = scale_sample(bus.lfsr_i);
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // Dropping enable_i wins over every other transition, including the RUN grant.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    grant_en  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.enable_i) begin
          state_nxt = S_WARMUP;
          wcnt_nxt  = '0;
        end
      end
      S_WARMUP: begin
        if (!bus.enable_i)                  state_nxt = S_IDLE;
        else if (wcnt == 8'(WARMUP - 1))    state_nxt = S_RUN;
        else                                wcnt_nxt  = wcnt + 8'd1;
      end
      S_RUN: begin
        if (!bus.enable_i) state_nxt = S_IDLE;
        else               grant_en  = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // First requester at or after the pointer, wrapping from NUM_REQ-1 to 0.
  always_comb begin
    hit   = 1'b0;
    idx   = ptr;
    probe = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      probe = PW'((int'(ptr) + i) % NUM_REQ);
      if (!hit && bus.req_i[probe]) begin
        hit = 1'b1;
        idx = probe;
      end
    end
  end

  assign grant   = grant_en && hit;
  assign ptr_nxt = (int'(idx) == NUM_REQ - 1) ? '0 : idx + PW'(1);

  // p0 -> p1: register grant, sample and running count
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      gnt_p1    <= '0;
      vld_p1    <= 1'b0;
      dither_p1 <= '0;
      cnt_p1    <= '0;
      ptr       <= '0;
    end else begin
      vld_p1 <= grant;
      gnt_p1 <= grant ? (NUM_REQ'(1) << idx) : '0;
      if (grant) dither_p1 <= dither_p0;
      if (state_nxt == S_IDLE) begin
        cnt_p1 <= '0;
        ptr    <= '0;
      end else if (grant) begin
        ptr <= ptr_nxt;
        if (cnt_p1 != 16'hFFFF) cnt_p1 <= cnt_p1 + 16'd1;
      end
    end
  end

  assign bus.gnt_o          = gnt_p1;
  assign bus.dither_o       = dither_p1;
  assign bus.dither_valid_o = vld_p1;
  assign bus.running_o      = (state == S_RUN);
  assign bus.gnt_count_o    = cnt_p1;
endmodule

// File: tb/tb_dither_arbiter.sv
// Directed bench for dither_arbiter: a scoreboard queue holds the expected grant/sample
// for each driven cycle and is compared one edge later.
module tb_dither_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  dither_arbiter_if #(.NUM_REQ(4), .WIDTH(20)) bus ();

  dither_arbiter #(.NUM_REQ(4), .WIDTH(20), .WARMUP(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0]  gnt;
    logic        vld;
    logic [19:0] dither;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          m_ptr = 0;
  logic [15:0] m_cnt = '0;
  logic [19:0] m_dither = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] shf(input logic [19:0] v);
`ifdef DITHER_ARB_SCALE_EN
    logic signed [19:0] t;
    t = v;
    return t >>> bus.scale_i;
`else
    return v;
`endif
  endfunction

  // One clock: predict from the current inputs, advance, compare, then drive a fresh LFSR value.
  task automatic cycle(input bit run);
    exp_t       e;
    int         k;
    logic [1:0] c;
    e.vld = 1'b0;
    e.gnt = '0;
    k = -1;
    if (run && bus.req_i != 4'b0) begin
      for (int i = 0; i < 4; i++) begin
        c = 2'((m_ptr + i) % 4);
        if (k < 0 && bus.req_i[c]) k = int'(c);
      end
      e.vld    = 1'b1;
      e.gnt    = 4'(1 << k);
      m_dither = shf(bus.lfsr_i);
      m_ptr    = (k + 1) % 4;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    e.dither = m_dither;
    e.cnt    = m_cnt;
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    chk("valid",  32'(bus.dither_valid_o), 32'(e.vld));
    chk("gnt",    32'(bus.gnt_o), 32'(e.gnt));
    chk("dither", 32'($unsigned(bus.dither_o)), 32'(e.dither));
    chk("count",  32'(bus.gnt_count_o), 32'(e.cnt));
    bus.lfsr_i = 20'($urandom());
  endtask

  logic [3:0]  rr_seq [5];
  logic [3:0]  sp_seq [4];
  logic [19:0] l;

  initial begin
    rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    sp_seq = '{4'b1000, 4'b0010, 4'b1000, 4'b0010};
    bus.enable_i = 1'b0;
    bus.req_i    = '0;
    bus.lfsr_i   = '0;
`ifdef DITHER_ARB_SCALE_EN
    bus.scale_i  = 2'd0;
`endif
    #2 reset = 1'b0;
    #1;
    chk("rst_gnt",     32'(bus.gnt_o), 32'h0);
    chk("rst_valid",   32'(bus.dither_valid_o), 32'h0);
    chk("rst_running", 32'(bus.running_o), 32'h0);
    chk("rst_count",   32'(bus.gnt_count_o), 32'h0);
    chk("rst_dither",  32'($unsigned(bus.dither_o)), 32'h0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // Warm-up with every channel requesting
    bus.enable_i = 1'b1;
    bus.req_i    = 4'b1111;
    bus.lfsr_i   = 20'($urandom());
    for (int i = 0; i < 16; i++) cycle(1'b0);
    chk("warm_running_lo", 32'(bus.running_o), 32'h0);
    cycle(1'b0);
    chk("warm_running_hi", 32'(bus.running_o), 32'h1);
    for (int i = 0; i < 5; i++) begin
      l = bus.lfsr_i;
      cycle(1'b1);
      chk("rr_seq",    32'(bus.gnt_o), 32'(rr_seq[i]));
      chk("rr_sample", 32'($unsigned(bus.dither_o)), 32'(l));
    end

    // Sparse requests: a grant to channel 3 first returns the pointer to 0
    bus.req_i = 4'b1000;
    cycle(1'b1);
    chk("sparse_seq", 32'(bus.gnt_o), 32'(sp_seq[0]));
    bus.req_i = 4'b1010;
    for (int i = 1; i < 4; i++) begin
      cycle(1'b1);
      chk("sparse_seq", 32'(bus.gnt_o), 32'(sp_seq[i]));
    end
    bus.req_i = 4'b0000;
    repeat (2) cycle(1'b1);
    bus.req_i = 4'b1111;
    cycle(1'b1);
    chk("ptr_kept", 32'(bus.gnt_o), 32'h4);

`ifdef DITHER_ARB_SCALE_EN
    bus.req_i   = 4'b0001;
    bus.lfsr_i  = 20'h80000;
    bus.scale_i = 2'd2;
    cycle(1'b1);
    chk("scale_neg", 32'($unsigned(bus.dither_o)), 32'hE0000);
    bus.lfsr_i  = 20'h7FFFF;
    bus.scale_i = 2'd3;
    cycle(1'b1);
    chk("scale_pos", 32'($unsigned(bus.dither_o)), 32'h0FFFF);
    bus.scale_i = 2'd0;
`endif

    // Enable drop with a pending request, then a full restart
    bus.req_i    = 4'b0001;
    bus.enable_i = 1'b0;
    m_ptr = 0;
    m_cnt = '0;
    cycle(1'b0);
    chk("drop_running", 32'(bus.running_o), 32'h0);
    bus.enable_i = 1'b1;
    bus.req_i    = 4'b1111;
    for (int i = 0; i < 17; i++) cycle(1'b0);
    cycle(1'b1);
    chk("reen_first", 32'(bus.gnt_o), 32'h1);
    repeat (2) cycle(1'b1);

    // Asynchronous reset between edges
    #2 reset = 1'b0;
    #1;
    chk("arst_gnt",     32'(bus.gnt_o), 32'h0);
    chk("arst_valid",   32'(bus.dither_valid_o), 32'h0);
    chk("arst_count",   32'(bus.gnt_count_o), 32'h0);
    chk("arst_running", 32'(bus.running_o), 32'h0);
    #2 reset = 1'b1;
    m_ptr    = 0;
    m_cnt    = '0;
    m_dither = '0;
    for (int i = 0; i < 17; i++) cycle(1'b0);
    cycle(1'b1);
    chk("arst_first", 32'(bus.gnt_o), 32'h1);

    // Saturation of the grant counter
    while (m_cnt != 16'hFFFF) cycle(1'b1);
    repeat (4) cycle(1'b1);
    chk("sat_count", 32'(bus.gnt_count_o), 32'hFFFF);
    chk("sat_valid", 32'(bus.dither_valid_o), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
